// File: rtl/mac_rx_frame_buf_pkg.sv
// Shared constants, FSM encodings and helpers for the MAC receive frame buffer.
package mac_rx_frame_buf_pkg;

   localparam int          MIN_LEN_DEF = 64;
   localparam int          MAX_LEN_DEF = 1518;
   localparam int          FCS_LEN     = 4;
   localparam int          LEN_W       = 11;
   localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_RECV = 2'd1,
      W_DROP = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_LOAD = 2'd1,
      R_SEND = 2'd2
   } rd_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/mac_rx_desc_fifo.sv
// Descriptor FIFO holding the payload length of each committed frame (first-word fall-through).
module mac_rx_desc_fifo #(
   parameter int WIDTH = 11,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2**AW];
   logic [AW:0]      wr_idx;
   logic [AW:0]      rd_idx;

   assign empty = (wr_idx == rd_idx);
   assign full  = (wr_idx[AW] != rd_idx[AW]) && (wr_idx[AW-1:0] == rd_idx[AW-1:0]);
   assign dout  = mem[rd_idx[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx <= '0;
         rd_idx <= '0;
      end else begin
         if (push && !full)
            wr_idx <= wr_idx + (AW+1)'(1);
         if (pop && !empty)
            rd_idx <= rd_idx + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_idx[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mac_rx_frame_buf.sv
// Store-and-forward receive buffer: commits CRC-good, filtered frames into a circular
// byte RAM (FCS stripped) and replays them on a ready/valid byte stream.
module mac_rx_frame_buf
   import mac_rx_frame_buf_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DESC_AW = 4,
   parameter int MIN_LEN = MIN_LEN_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic        mac_rx_clk,
   input  logic        rst_n,
   input  logic        mac_rx_sof,
   input  logic        mac_rx_eof,
   input  logic        mac_rx_valid,
   input  logic [7:0]  mac_rx_data,
   input  logic [47:0] local_mac,
   input  logic        promisc,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   output logic        m_tlast,
   input  logic        m_tready,
   output logic [10:0] m_tlen,
   output logic [15:0] cnt_ok,
   output logic [15:0] cnt_drop
);

   localparam int PW    = ADDR_W + 1;
   localparam int CNT_W = 12;

   logic [7:0]        ram [2**ADDR_W];
   logic [7:0]        ram_q;
   logic [ADDR_W-1:0] ram_waddr, ram_raddr;
   logic              ram_we;

   wr_state_t         wr_state;
   rd_state_t         rd_state;
   logic [PW-1:0]     wr_ptr, commit_ptr, frame_start, rd_ptr;
   logic [PW-1:0]     occ_next, commit_val;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [39:0]       dst_hi;
   logic [47:0]       dest;
   logic              start, recv_byte, ovf, too_long, addr_bad, commit_ok;
   logic [LEN_W-1:0]  desc_din, desc_dout, idx;
   logic              desc_pop, desc_full, desc_empty;
   logic              hs;

   assign start      = mac_rx_valid & mac_rx_sof;
   assign cnt_next   = cnt + CNT_W'(1);
   assign occ_next   = wr_ptr - rd_ptr + PW'(1);
   assign ovf        = occ_next[ADDR_W];
   assign too_long   = cnt_next > CNT_W'(MAX_LEN);
   assign dest       = {dst_hi, mac_rx_data};
   assign addr_bad   = !promisc && (dest != local_mac) && (dest != BCAST_MAC);
   assign recv_byte  = (wr_state == W_RECV) && mac_rx_valid && !mac_rx_sof && !too_long && !ovf;
   assign commit_ok  = recv_byte && mac_rx_eof && (cnt_next >= CNT_W'(MIN_LEN)) && !desc_full;
   assign commit_val = frame_start + PW'(cnt_next) - PW'(FCS_LEN);
   assign desc_din   = LEN_W'(cnt_next - CNT_W'(FCS_LEN));
   assign ram_we     = start | recv_byte;
   assign ram_waddr  = start ? commit_ptr[ADDR_W-1:0] : wr_ptr[ADDR_W-1:0];

   // Write side: every drop rewinds wr_ptr to commit_ptr, so frame_start always equals commit_ptr.
   always_ff @(posedge mac_rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state    <= W_IDLE;
         wr_ptr      <= '0;
         commit_ptr  <= '0;
         frame_start <= '0;
         cnt         <= '0;
         dst_hi      <= '0;
         cnt_ok      <= '0;
         cnt_drop    <= '0;
      end else if (start) begin
         if (wr_state == W_RECV)
            cnt_drop <= sat_inc16(cnt_drop);
         frame_start <= commit_ptr;
         wr_ptr      <= commit_ptr + PW'(1);
         cnt         <= CNT_W'(1);
         dst_hi      <= {dst_hi[31:0], mac_rx_data};
         wr_state    <= W_RECV;
      end else begin
         case (wr_state)
            W_RECV: begin
               if (!mac_rx_valid) begin
                  wr_ptr   <= commit_ptr;
                  cnt_drop <= sat_inc16(cnt_drop);
                  wr_state <= W_IDLE;
               end else if (too_long || ovf) begin
                  wr_ptr   <= commit_ptr;
                  cnt_drop <= sat_inc16(cnt_drop);
                  wr_state <= W_DROP;
               end else if (mac_rx_eof) begin
                  if (commit_ok) begin
                     commit_ptr <= commit_val;
                     wr_ptr     <= commit_val;
                     cnt_ok     <= sat_inc16(cnt_ok);
                  end else begin
                     wr_ptr   <= commit_ptr;
                     cnt_drop <= sat_inc16(cnt_drop);
                  end
                  wr_state <= W_IDLE;
               end else if ((cnt_next == CNT_W'(6)) && addr_bad) begin
                  wr_ptr   <= commit_ptr;
                  cnt_drop <= sat_inc16(cnt_drop);
                  wr_state <= W_DROP;
               end else begin
                  wr_ptr <= wr_ptr + PW'(1);
                  cnt    <= cnt_next;
                  dst_hi <= {dst_hi[31:0], mac_rx_data};
               end
            end
            W_DROP: if (!mac_rx_valid) wr_state <= W_IDLE;
            default: ;
         endcase
      end
   end

   mac_rx_desc_fifo #(.WIDTH(LEN_W), .AW(DESC_AW)) u_desc_fifo (
      .clk   (mac_rx_clk),
      .rst_n (rst_n),
      .push  (commit_ok),
      .din   (desc_din),
      .pop   (desc_pop),
      .dout  (desc_dout),
      .full  (desc_full),
      .empty (desc_empty)
   );

   // Read address looks one byte ahead on a handshake so ram_q always holds the byte at rd_ptr.
   assign hs        = m_tvalid & m_tready;
   assign ram_raddr = hs ? rd_ptr[ADDR_W-1:0] + ADDR_W'(1) : rd_ptr[ADDR_W-1:0];
   assign desc_pop  = !desc_empty && ((rd_state == R_IDLE) || ((rd_state == R_SEND) && hs && m_tlast));
   assign m_tdata   = m_tvalid ? ram_q : 8'h00;

   always_ff @(posedge mac_rx_clk) begin
      if (ram_we)
         ram[ram_waddr] <= mac_rx_data;
      ram_q <= ram[ram_raddr];
   end

   always_ff @(posedge mac_rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= R_IDLE;
         rd_ptr   <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tlen   <= '0;
         idx      <= '0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (desc_pop) begin
                  m_tlen   <= desc_dout;
                  rd_state <= R_LOAD;
               end
            end
            R_LOAD: begin
               m_tvalid <= 1'b1;
               m_tlast  <= (m_tlen == LEN_W'(1));
               idx      <= '0;
               rd_state <= R_SEND;
            end
            R_SEND: begin
               if (hs) begin
                  rd_ptr <= rd_ptr + PW'(1);
                  if (m_tlast) begin
                     m_tvalid <= 1'b0;
                     m_tlast  <= 1'b0;
                     if (desc_pop) begin
                        m_tlen   <= desc_dout;
                        rd_state <= R_LOAD;
                     end else begin
                        rd_state <= R_IDLE;
                     end
                  end else begin
                     idx     <= idx + LEN_W'(1);
                     m_tlast <= ((idx + LEN_W'(2)) == m_tlen);
                  end
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_rx_frame_buf.sv
// Randomized bench for mac_rx_frame_buf, checked against a frame-level accept/drop and byte-queue model.
module tb_mac_rx_frame_buf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        sof = 1'b0, eof = 1'b0, vld = 1'b0;
   logic [7:0]  data = 8'h00;
   logic [47:0] local_mac = 48'h02_11_22_33_44_55;
   logic        promisc = 1'b0;
   logic        rdy_a = 1'b0, rdy_b = 1'b0;

   logic [7:0]  a_tdata, b_tdata;
   logic        a_tvalid, a_tlast, b_tvalid, b_tlast;
   logic [10:0] a_tlen, b_tlen;
   logic [15:0] a_cnt_ok, a_cnt_drop, b_cnt_ok, b_cnt_drop;

   always #5 clk = ~clk;

   mac_rx_frame_buf #(.ADDR_W(12)) dut_a (
      .mac_rx_clk(clk), .rst_n(rst_n), .mac_rx_sof(sof), .mac_rx_eof(eof),
      .mac_rx_valid(vld), .mac_rx_data(data), .local_mac(local_mac), .promisc(promisc),
      .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tlast(a_tlast), .m_tready(rdy_a),
      .m_tlen(a_tlen), .cnt_ok(a_cnt_ok), .cnt_drop(a_cnt_drop));

   mac_rx_frame_buf #(.ADDR_W(8)) dut_b (
      .mac_rx_clk(clk), .rst_n(rst_n), .mac_rx_sof(sof), .mac_rx_eof(eof),
      .mac_rx_valid(vld), .mac_rx_data(data), .local_mac(local_mac), .promisc(promisc),
      .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tlast(b_tlast), .m_tready(rdy_b),
      .m_tlen(b_tlen), .cnt_ok(b_cnt_ok), .cnt_drop(b_cnt_drop));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   logic [7:0] frame[$];
   logic [7:0] exp_q[$];
   int         exp_len_q[$];
   int         exp_ok = 0, exp_drop = 0;
   bit         mon_a = 1'b1;
   bit         rdy_rand = 1'b0;
   logic [7:0] exp_b[$];
   int         b_bytes = 0, b_frames = 0;

   function automatic bit accept(input int len, input logic [47:0] dst, input bit good, input bit prm);
      if (!good) return 1'b0;
      if (len < 64 || len > 1518) return 1'b0;
      if (!prm && dst != local_mac && dst != 48'hFFFF_FFFF_FFFF) return 1'b0;
      return 1'b1;
   endfunction

   task automatic build_frame(input int len, input logic [47:0] dst);
      frame.delete();
      for (int i = 0; i < len; i++)
         frame.push_back(i < 6 ? dst[47-8*i -: 8] : 8'($urandom));
   endtask

   task automatic model_frame(input logic [47:0] dst, input bit good);
      int len = frame.size();
      if (accept(len, dst, good, promisc)) begin
         for (int i = 0; i < len - 4; i++) exp_q.push_back(frame[i]);
         exp_len_q.push_back(len - 4);
         exp_ok++;
      end else begin
         exp_drop++;
      end
   endtask

   task automatic drive_frame(input bit good, input int nbytes, input int gap);
      for (int i = 0; i < nbytes; i++) begin
         @(posedge clk); #1;
         vld  = 1'b1;
         sof  = (i == 0);
         data = frame[i];
         eof  = good && (i == frame.size() - 1);
      end
      if (gap > 0) begin
         @(posedge clk); #1;
         vld = 1'b0; sof = 1'b0; eof = 1'b0; data = 8'h00;
         repeat (gap - 1) @(posedge clk);
      end
   endtask

   task automatic send(input int len, input logic [47:0] dst, input bit good, input int gap);
      build_frame(len, dst);
      model_frame(dst, good);
      drive_frame(good, len, gap);
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      while ((exp_len_q.size() != 0 || a_tvalid) && t < 5000) begin
         @(posedge clk);
         t++;
      end
      check_eq(tag, 64'(exp_len_q.size()), 64'(0));
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input string tag);
      check_eq({tag, "_cnt_ok"}, 64'(a_cnt_ok), 64'(exp_ok));
      check_eq({tag, "_cnt_drop"}, 64'(a_cnt_drop), 64'(exp_drop));
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_tvalid"}, 64'(a_tvalid), 64'(0));
      check_eq({tag, "_tdata"}, 64'(a_tdata), 64'(0));
      check_eq({tag, "_tlast"}, 64'(a_tlast), 64'(0));
      check_eq({tag, "_tlen"}, 64'(a_tlen), 64'(0));
      check_eq({tag, "_cnt_ok"}, 64'(a_cnt_ok), 64'(0));
      check_eq({tag, "_cnt_drop"}, 64'(a_cnt_drop), 64'(0));
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; vld = 1'b0; sof = 1'b0; eof = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial forever begin
      @(posedge clk); #2;
      if (rdy_rand) rdy_a = ($urandom_range(0, 3) != 0);
   end

   // Output monitor for the 4 KB instance
   int         mon_idx = 0;
   bit         stall_prev = 1'b0;
   logic [7:0] p_data;
   logic       p_last;
   logic [10:0] p_len;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
         mon_idx    = 0;
      end else if (mon_a) begin
         if (stall_prev) begin
            check_eq("hold_tvalid", 64'(a_tvalid), 64'(1));
            check_eq("hold_tdata", 64'(a_tdata), 64'(p_data));
            check_eq("hold_tlast", 64'(a_tlast), 64'(p_last));
            check_eq("hold_tlen", 64'(a_tlen), 64'(p_len));
         end
         if (a_tvalid && rdy_a) begin
            if (exp_len_q.size() == 0) begin
               check_eq("spurious_tvalid", 64'(a_tvalid), 64'(0));
            end else begin
               check_eq("tdata", 64'(a_tdata), 64'(exp_q.pop_front()));
               check_eq("tlen", 64'(a_tlen), 64'(exp_len_q[0]));
               check_eq("tlast", 64'(a_tlast), 64'(mon_idx + 1 == exp_len_q[0]));
               mon_idx++;
               if (mon_idx == exp_len_q[0]) begin
                  void'(exp_len_q.pop_front());
                  mon_idx = 0;
               end
            end
         end
         stall_prev = a_tvalid && !rdy_a;
         p_data = a_tdata;
         p_last = a_tlast;
         p_len  = a_tlen;
      end
   end

   // Output monitor for the 256-byte instance
   always @(negedge clk) begin
      if (rst_n && b_tvalid && rdy_b) begin
         b_bytes++;
         if (b_tlast) b_frames++;
         if (exp_b.size() > 0) check_eq("b_tdata", 64'(b_tdata), 64'(exp_b.pop_front()));
         else check_eq("b_spurious_tvalid", 64'(b_tvalid), 64'(0));
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, %0d expected bytes outstanding", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int          b_stored, b_ok, b_drop, len, dsel;
      bit          good;
      logic [47:0] dst;

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_outputs_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      rdy_a = 1'b1;

      // Single good minimum-size frame
      send(64, local_mac, 1'b1, 3);
      wait_drain("t1_drain");
      check_counts("t1");

      // Bad CRC followed by a good frame
      send(100, local_mac, 1'b0, 3);
      send(80, local_mac, 1'b1, 3);
      wait_drain("t2_drain");
      check_counts("t2");

      // Destination filtering
      dst = 48'h0A_BB_CC_DD_EE_01;
      build_frame(70, dst);
      promisc = 1'b0;
      model_frame(dst, 1'b1);
      drive_frame(1'b1, 70, 3);
      promisc = 1'b1;
      model_frame(dst, 1'b1);
      drive_frame(1'b1, 70, 3);
      promisc = 1'b0;
      send(72, 48'hFFFF_FFFF_FFFF, 1'b1, 3);
      wait_drain("t3_drain");
      check_counts("t3");

      // Runt and oversize
      send(40, local_mac, 1'b1, 3);
      send(1600, local_mac, 1'b1, 3);
      wait_drain("t4_drain");
      check_counts("t4");

      // Randomized mix with random back-pressure
      rdy_rand = 1'b1;
      for (int f = 0; f < 12; f++) begin
         len  = $urandom_range(40, 200);
         good = ($urandom_range(0, 4) != 0);
         dsel = $urandom_range(0, 2);
         dst  = (dsel == 0) ? local_mac : (dsel == 1) ? 48'hFFFF_FFFF_FFFF
                                                     : {16'h0A00 | 16'($urandom), 32'($urandom)};
         promisc = ($urandom_range(0, 3) == 0);
         send(len, dst, good, $urandom_range(1, 4));
      end
      promisc = 1'b0;
      wait_drain("rand_drain");
      check_counts("rand");
      rdy_rand = 1'b0;
      #3 rdy_a = 1'b1;

      // Overflow on the 256-byte instance with a stalled sink
      mon_a = 1'b0;
      rdy_b = 1'b0;
      pulse_reset();
      b_stored = 0; b_ok = 0; b_drop = 0;
      for (int f = 0; f < 5; f++) begin
         build_frame(100, local_mac);
         if (b_stored + 100 < 256) begin
            for (int i = 0; i < 96; i++) exp_b.push_back(frame[i]);
            b_stored += 96;
            b_ok++;
         end else begin
            b_drop++;
         end
         drive_frame(1'b1, 100, 3);
      end
      repeat (10) @(posedge clk);
      #1;
      check_eq("t5_cnt_ok", 64'(b_cnt_ok), 64'(b_ok));
      check_eq("t5_cnt_drop", 64'(b_cnt_drop), 64'(b_drop));
      check_eq("t5_stall_tvalid", 64'(b_tvalid), 64'(1));
      check_eq("t5_stall_tlen", 64'(b_tlen), 64'(96));
      b_bytes = 0; b_frames = 0;
      rdy_b = 1'b1;
      repeat (600) @(posedge clk);
      #1;
      check_eq("t5_bytes_out", 64'(b_bytes), 64'(192));
      check_eq("t5_frames_out", 64'(b_frames), 64'(2));
      check_eq("t5_left", 64'(exp_b.size()), 64'(0));
      rdy_b = 1'b0;

      // Back-to-back frames, then reset in the middle of a fourth
      pulse_reset();
      exp_q.delete(); exp_len_q.delete();
      exp_ok = 0; exp_drop = 0;
      mon_a = 1'b1;
      rdy_rand = 1'b1;
      send($urandom_range(64, 200), local_mac, 1'b1, 0);
      send($urandom_range(64, 200), local_mac, 1'b1, 0);
      send($urandom_range(64, 200), local_mac, 1'b1, 2);
      wait_drain("t6_drain");
      check_counts("t6");
      build_frame(120, local_mac);
      drive_frame(1'b1, 50, 0);
      @(posedge clk); #1;
      rst_n = 1'b0; vld = 1'b0; sof = 1'b0; eof = 1'b0;
      rdy_rand = 1'b0;
      repeat (2) @(posedge clk);
      #3 rdy_a = 1'b1;
      check_outputs_zero("t6_in_reset");
      rst_n = 1'b1;
      exp_ok = 0; exp_drop = 0;
      repeat (20) @(posedge clk);
      #1;
      check_eq("t6_no_resume_tvalid", 64'(a_tvalid), 64'(0));
      check_counts("t6_after_reset");
      send(64, local_mac, 1'b1, 3);
      wait_drain("t6_post_drain");
      check_counts("t6_post");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
